// File: rtl/rxuart_pkg.sv
// Shared constants and types for the parametrised UART receiver.
package rxuart_pkg;

    // Parity mode encodings
    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Minimum bits needed to count 0..v-1 (never less than 1)
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rxuart_param_if.sv
// Output word bus of the UART receiver: holding register plus valid/ready.
interface rxuart_param_if #(
    parameter int unsigned DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (output data, valid, parity_err, frame_err, overrun, input ready);
    modport slave  (input  data, valid, parity_err, frame_err, overrun, output ready);
endinterface

// File: rtl/rx_sampler.sv
// Line conditioning: 2-FF synchroniser, falling-edge detect, 3-sample majority.
module rx_sampler (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall_c,
    output logic o_vote_c
);
    logic r_sync1, r_sync2, r_h1, r_h2;

    // Synchroniser and two-deep history of the synchronised line (idle high)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_h1    <= 1'b1;
            r_h2    <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_h1    <= r_sync2;
            r_h2    <= r_h1;
        end
    end

    assign o_rx_s   = r_sync2;
    assign o_fall_c = r_h1 & ~r_sync2;
    // Vote over the current and two previous samples (counts MID+1, MID, MID-1)
    assign o_vote_c = (r_sync2 & r_h1) | (r_sync2 & r_h2) | (r_h1 & r_h2);
endmodule

// File: rtl/rxuart_param.sv
// Parametrised UART receiver with majority sampling and a valid/ready output register.
import rxuart_pkg::*;

module rxuart_param #(
    parameter int unsigned CLK_FREQ  = 12_000_000,
    parameter int unsigned BAUDRATE  = 230_400,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rx,
    rxuart_param_if.master bus
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUDRATE;
    localparam int unsigned MID          = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W        = clog2(DATA_BITS + 1);

    localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
    localparam logic [2:0] S_START  = 3'(ST_START);
    localparam logic [2:0] S_DATA   = 3'(ST_DATA);
    localparam logic [2:0] S_PARITY = 3'(ST_PARITY);
    localparam logic [2:0] S_STOP   = 3'(ST_STOP);
    localparam logic [2:0] S_DONE   = 3'(ST_DONE);

    logic [2:0]           r_state, w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [BIT_W-1:0]     r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err, r_frame_err, r_armed;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_out_perr, r_out_ferr, r_overrun;
    logic                 w_rx_s, w_fall, w_vote;
    logic                 w_samp, w_wrap, w_last_data, w_last_stop;

    rx_sampler u_sampler (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_rx     (rx),
        .o_rx_s   (w_rx_s),
        .o_fall_c (w_fall),
        .o_vote_c (w_vote)
    );

    assign w_samp      = (r_cnt == CNT_W'(MID + 1));
    assign w_wrap      = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign w_last_data = (r_bit == BIT_W'(DATA_BITS - 1));
    assign w_last_stop = (r_bit == BIT_W'(STOP_BITS - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_fall && r_armed) w_next = S_START;
            S_START: begin
                if (w_samp && w_vote) w_next = S_IDLE;
                else if (w_wrap)      w_next = S_DATA;
            end
            S_DATA:   if (w_wrap && w_last_data)
                          w_next = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            S_PARITY: if (w_wrap) w_next = S_STOP;
            S_STOP:   if (w_samp && w_last_stop) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Baud counter, bit index, shift register and per-frame error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_wrap) r_cnt <= '0;
            else                             r_cnt <= r_cnt + CNT_W'(1);
            case (r_state)
                S_IDLE: begin
                    r_bit       <= '0;
                    r_par_err   <= 1'b0;
                    r_frame_err <= 1'b0;
                end
                S_DATA: begin
                    if (w_samp) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                    if (w_wrap) r_bit <= w_last_data ? '0 : r_bit + BIT_W'(1);
                end
                S_PARITY: if (w_samp)
                    r_par_err <= ((^r_shift) ^ w_vote) != (PARITY == PAR_ODD);
                S_STOP: if (w_samp) begin
                    if (!w_vote) r_frame_err <= 1'b1;
                    r_bit <= r_bit + BIT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // A line left low by a framing error must rise before a new start is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_armed <= 1'b1;
        else if (w_rx_s)                         r_armed <= 1'b1;
        else if (r_state == S_DONE && r_frame_err) r_armed <= 1'b0;
    end

    // Single-entry holding register with valid/ready handshake and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_out_perr <= 1'b0;
            r_out_ferr <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (r_state == S_DONE) begin
            if (!r_valid || bus.ready) begin
                r_data     <= r_shift;
                r_valid    <= 1'b1;
                r_out_perr <= r_par_err;
                r_out_ferr <= r_frame_err;
            end else begin
                r_overrun  <= 1'b1;
            end
        end else if (r_valid && bus.ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.data       = r_data;
    assign bus.valid      = r_valid;
    assign bus.parity_err = r_out_perr;
    assign bus.frame_err  = r_out_ferr;
    assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_rxuart_param.sv
// Scoreboard bench for rxuart_param: three configurations driven with random frames.
module tb_rxuart_param;
    localparam int CPB = 52;

    typedef struct {
        int         d;
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] rx_line = 3'b111;
    logic [2:0] rdy = 3'b111;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   m_hold[3];
    bit   m_ovr[3];

    always #5 clk = ~clk;

    rxuart_param_if #(.DATA_BITS(8)) if0 ();
    rxuart_param_if #(.DATA_BITS(8)) if1 ();
    rxuart_param_if #(.DATA_BITS(7)) if2 ();

    assign if0.ready = rdy[0];
    assign if1.ready = rdy[1];
    assign if2.ready = rdy[2];

    rxuart_param dut0 (.clk(clk), .rst_n(rst_n), .rx(rx_line[0]), .bus(if0));
    rxuart_param #(.PARITY(2)) dut1 (.clk(clk), .rst_n(rst_n), .rx(rx_line[1]), .bus(if1));
    rxuart_param #(.DATA_BITS(7), .STOP_BITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .rx(rx_line[2]), .bus(if2));

    logic [2:0]      w_valid, w_pe, w_fe, w_ovr;
    logic [2:0][8:0] w_data;
    assign w_valid = {if2.valid, if1.valid, if0.valid};
    assign w_pe    = {if2.parity_err, if1.parity_err, if0.parity_err};
    assign w_fe    = {if2.frame_err, if1.frame_err, if0.frame_err};
    assign w_ovr   = {if2.overrun, if1.overrun, if0.overrun};
    assign w_data  = {9'(if2.data), 9'(if1.data), 9'(if0.data)};

    // Frame format of each instance
    function automatic int db_of(input int d);  return (d == 2) ? 7 : 8; endfunction
    function automatic int par_of(input int d); return (d == 1) ? 2 : 0; endfunction
    function automatic int sb_of(input int d);  return (d == 2) ? 2 : 1; endfunction

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int d, input logic [8:0] data, input logic pe, input logic fe);
        exp_t e;
        e.d = d; e.data = data; e.pe = pe; e.fe = fe;
        if (rdy[d]) q.push_back(e);
        else if (!m_hold[d]) begin
            q.push_back(e);
            m_hold[d] = 1'b1;
        end else m_ovr[d] = 1'b1;
    endtask

    // Model: compute the expected word from the frame rules, then shift the frame onto the line
    task automatic send_frame(input int d, input logic [8:0] val, input bit bad_par, input bit bad_stop);
        logic [8:0] v;
        logic [8:0] mask;
        logic       p;
        mask = 9'((1 << db_of(d)) - 1);
        v    = val & mask;
        p    = ^v;
        if (par_of(d) == 1) p = ~p;
        if (bad_par) p = ~p;
        push_exp(d, v, (par_of(d) != 0) && bad_par, bad_stop);
        rx_line[d] = 1'b0;
        tick(CPB);
        for (int i = 0; i < db_of(d); i++) begin
            rx_line[d] = v[i];
            tick(CPB);
        end
        if (par_of(d) != 0) begin
            rx_line[d] = p;
            tick(CPB);
        end
        for (int s = 0; s < sb_of(d); s++) begin
            rx_line[d] = !(bad_stop && s == sb_of(d) - 1);
            tick(CPB);
        end
        rx_line[d] = 1'b1;
    endtask

    // Monitor: every accepted word is compared against the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (w_valid[d] && rdy[d]) begin
                    if (q.size() == 0 || q[0].d != d) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_word dut%0d: got 0x%0h, none expected", d, w_data[d]);
                    end else begin
                        mon_e = q.pop_front();
                        chk($sformatf("data dut%0d", d), w_data[d], mon_e.data);
                        chk($sformatf("parity_err dut%0d", d), 9'(w_pe[d]), 9'(mon_e.pe));
                        chk($sformatf("frame_err dut%0d", d), 9'(w_fe[d]), 9'(mon_e.fe));
                    end
                end
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            tick(1);
            n++;
        end
        chk("queue_drained", 9'(q.size()), 9'd0);
    endtask

    initial begin
        bit bs, bp;
        tick(5);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_valid dut%0d", d), 9'(w_valid[d]), 9'd0);
            chk($sformatf("reset_data dut%0d", d), w_data[d], 9'd0);
            chk($sformatf("reset_flags dut%0d", d), 9'({w_pe[d], w_fe[d], w_ovr[d]}), 9'd0);
        end
        rst_n = 1'b1;
        tick(5);

        // 8N1 back-to-back, then random traffic
        send_frame(0, 9'h40, 0, 0);
        tick(2);
        send_frame(0, 9'h61, 0, 0);
        tick(5);
        repeat (8) begin
            bs = ($urandom_range(0, 3) == 0);
            send_frame(0, 9'($urandom), 0, bs);
            tick(bs ? 3 + $urandom_range(0, 8) : $urandom_range(0, 8));
        end
        drain();

        // Short low glitch must not start a frame
        rx_line[0] = 1'b0;
        tick(10);
        rx_line[0] = 1'b1;
        tick(60);
        chk("false_start_valid", 9'(w_valid[0]), 9'd0);

        // Framing error followed by a clean frame
        send_frame(0, 9'h49, 0, 1);
        tick(5);
        send_frame(0, 9'h19, 0, 0);
        tick(5);

        // Held-low break: exactly one zero word with frame_err
        push_exp(0, 9'h00, 1'b0, 1'b1);
        rx_line[0] = 1'b0;
        tick(30 * CPB);
        rx_line[0] = 1'b1;
        tick(20);
        drain();

        // Overrun: second frame dropped while the first is held
        rdy[0] = 1'b0;
        send_frame(0, 9'h40, 0, 0);
        tick(3);
        send_frame(0, 9'h61, 0, 0);
        tick(10);
        chk("ovr_valid_held", 9'(w_valid[0]), 9'd1);
        chk("ovr_data_held", w_data[0], 9'h40);
        chk("ovr_flag", 9'(w_ovr[0]), 9'(m_ovr[0]));
        rdy[0] = 1'b1;
        m_hold[0] = 1'b0;
        tick(3);
        chk("ovr_valid_dropped", 9'(w_valid[0]), 9'd0);
        chk("ovr_sticky", 9'(w_ovr[0]), 9'(m_ovr[0]));
        drain();

        // Reset during bit 3 of 0xA5, then a clean 0x5A
        rx_line[0] = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            rx_line[0] = (i == 0 || i == 2);
            tick(CPB);
        end
        rx_line[0] = 1'b0;
        tick(CPB / 2);
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) m_ovr[d] = 1'b0;
        tick(3);
        rx_line[0] = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2 * CPB);
        chk("rst_valid", 9'(w_valid[0]), 9'd0);
        chk("rst_overrun", 9'(w_ovr[0]), 9'(m_ovr[0]));
        send_frame(0, 9'h5A, 0, 0);
        tick(5);
        drain();

        // Even parity instance
        send_frame(1, 9'h93, 0, 0);
        tick(4);
        send_frame(1, 9'h29, 1, 0);
        tick(4);
        repeat (8) begin
            bp = $urandom_range(0, 1) == 1;
            send_frame(1, 9'($urandom), bp, 0);
            tick($urandom_range(0, 8));
        end
        drain();

        // 7-bit, two-stop instance
        send_frame(2, 9'h5A, 0, 0);
        tick(3);
        repeat (8) begin
            bs = ($urandom_range(0, 3) == 0);
            send_frame(2, 9'($urandom), 0, bs);
            tick(bs ? 3 + $urandom_range(0, 8) : $urandom_range(0, 8));
        end
        drain();

        tick(20);
        for (int d = 0; d < 3; d++)
            chk($sformatf("final_overrun dut%0d", d), 9'(w_ovr[d]), 9'(m_ovr[d]));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
